// File: rtl/led_pkg.sv
// Shared widths, default timing and state encoding for the LED-128 job controller.
package led_pkg;

    localparam int KEY_W = 128;
    localparam int BLK_W = 64;

    localparam logic [7:0]  DEF_RST_CYCLES     = 8'd5;
    localparam logic [7:0]  DEF_START_CYCLES   = 8'd2;
    localparam logic [15:0] DEF_TIMEOUT_CYCLES = 16'd12000;

    typedef logic req_id_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CRST   = 3'd1,
        CGAP   = 3'd2,
        CSTART = 3'd3,
        CWAIT  = 3'd4,
        RESP   = 3'd5
    } state_e;

endpackage

// File: rtl/led_rr_arb2.sv
// Two-input round-robin arbiter; remembers the last granted requester so that
// simultaneous requests alternate.
module led_rr_arb2
    import led_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en_i,
    input  logic    req0_i,
    input  logic    req1_i,
    output req_id_t grant_o,
    output logic    rdy0_o,
    output logic    rdy1_o
);

    req_id_t last_grant_q;

    always_comb begin
        grant_o = 1'b0;
        if (req0_i && req1_i) begin
            grant_o = ~last_grant_q;
        end else if (req1_i) begin
            grant_o = 1'b1;
        end
    end

    assign rdy0_o = en_i && req0_i && (grant_o == 1'b0);
    assign rdy1_o = en_i && req1_i && (grant_o == 1'b1);

    // Reset to 1 so requester 0 wins the first contested grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else if (rdy0_o || rdy1_o) begin
            last_grant_q <= grant_o;
        end
    end

endmodule

// File: rtl/led_job_ctrl.sv
// Two-requester job sequencer for one shared led_serial LED-128 core.
// Optional CWAIT watchdog enabled by defining LED_CTRL_TIMEOUT_EN.
module led_job_ctrl
    import led_pkg::*;
#(
    parameter logic [7:0]  RST_CYCLES     = DEF_RST_CYCLES,
    parameter logic [7:0]  START_CYCLES   = DEF_START_CYCLES,
    parameter logic [15:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [KEY_W-1:0] req0_key,
    input  logic [BLK_W-1:0] req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [KEY_W-1:0] req1_key,
    input  logic [BLK_W-1:0] req1_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [BLK_W-1:0] rsp_data,
    output logic             rsp_err,
    output logic             core_reset,
    output logic             core_start,
    output logic [KEY_W-1:0] core_keyi,
    output logic [BLK_W-1:0] core_datai,
    input  logic [BLK_W-1:0] core_dataq,
    input  logic             core_done,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q;
    req_id_t          grant;
    req_id_t          id_q;
    logic             accept;
    logic             timeout;
    logic [KEY_W-1:0] keyi_q;
    logic [BLK_W-1:0] datai_q;
    logic [BLK_W-1:0] rsp_data_q;

    led_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (reset),
        .en_i    (state_q == IDLE),
        .req0_i  (req0_valid),
        .req1_i  (req1_valid),
        .grant_o (grant),
        .rdy0_o  (req0_ready),
        .rdy1_o  (req1_ready)
    );

    assign accept = req0_ready || req1_ready;

`ifdef LED_CTRL_TIMEOUT_EN
    logic [15:0] wd_q;
    logic        rsp_err_q;

    // A done arriving on the limit cycle takes priority over the timeout.
    assign timeout = (state_q == CWAIT) && !core_done && (wd_q == TIMEOUT_CYCLES);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q      <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (state_q == CSTART) begin
                wd_q <= '0;
            end else if ((state_q == CWAIT) && (wd_q != TIMEOUT_CYCLES)) begin
                wd_q <= wd_q + 16'd1;
            end
            if (state_q == CWAIT) begin
                if (core_done) begin
                    rsp_err_q <= 1'b0;
                end else if (timeout) begin
                    rsp_err_q <= 1'b1;
                end
            end
        end
    end

    assign rsp_err = rsp_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
    assign rsp_err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = CRST;
            CRST:    if (cnt_q <= 8'd1) state_d = CGAP;
            CGAP:    state_d = CSTART;
            CSTART:  if (cnt_q <= 8'd1) state_d = CWAIT;
            CWAIT:   if (core_done || timeout) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core_reset = 1'b0;
        core_start = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            IDLE:    busy       = 1'b0;
            CRST:    core_reset = 1'b1;
            CSTART:  core_start = 1'b1;
            RESP:    rsp_valid  = 1'b1;
            default: ;
        endcase
    end

    // Phase counter: loads on entry, counts down to 1 and holds there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE:         if (accept) cnt_q <= RST_CYCLES;
                CGAP:         cnt_q <= START_CYCLES;
                CRST, CSTART: if (cnt_q > 8'd1) cnt_q <= cnt_q - 8'd1;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            keyi_q     <= '0;
            datai_q    <= '0;
            id_q       <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                keyi_q  <= grant ? req1_key  : req0_key;
                datai_q <= grant ? req1_data : req0_data;
                id_q    <= grant;
            end
            if (state_q == CWAIT) begin
                if (core_done) begin
                    rsp_data_q <= core_dataq;
                end else if (timeout) begin
                    rsp_data_q <= '0;
                end
            end
        end
    end

    assign core_keyi  = keyi_q;
    assign core_datai = datai_q;
    assign rsp_id     = id_q;
    assign rsp_data   = rsp_data_q;

endmodule
